// File: rtl/pes_downco.sv
// Loadable down-counter/timer with terminal-count pulse and optional auto-reload.
// Single clock domain; synchronous active-low reset.
module pes_downco #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic [WIDTH-1:0] start_val;

    // A load that coincides with start supplies the start value directly.
    assign start_val = load ? load_val : q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_next  = state;
        q_next      = q;
        reload_next = reload_reg;
        tc_next     = 1'b0;

        if (load) begin
            reload_next = load_val;
        end

        case (state)
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (q > ONE) begin
                    q_next = q - ONE;
                end else if (auto_reload && (reload_reg != ZERO)) begin
                    q_next  = reload_reg;
                    tc_next = 1'b1;
                end else begin
                    q_next     = ZERO;
                    tc_next    = 1'b1;
                    state_next = DONE;
                end
            end
            default: begin
                // IDLE and DONE share handling; stop only clears DONE.
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    q_next = start_val;
                    if (start_val != ZERO) begin
                        state_next = RUN;
                    end else begin
                        tc_next    = 1'b1;
                        state_next = DONE;
                    end
                end else if (load) begin
                    q_next     = load_val;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state      <= IDLE;
            q          <= ZERO;
            reload_reg <= ZERO;
            tc         <= 1'b0;
        end else begin
            state      <= state_next;
            q          <= q_next;
            reload_reg <= reload_next;
            tc         <= tc_next;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_pes_downco.sv
// Directed self-checking bench for pes_downco; expected values are hand-computed.
module tb_pes_downco;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       stop;
    logic       auto_reload;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       tc;

    int vectors   = 0;
    int miscompares = 0;
    int n;

    pes_downco #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .tc          (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] eq, input logic eb,
                             input logic ed, input logic et);
        check({tag, ".q"}, {24'd0, q}, {24'd0, eq});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
        check({tag, ".done"}, {31'd0, done}, {31'd0, ed});
        check({tag, ".tc"}, {31'd0, tc}, {31'd0, et});
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; load_val = 8'd0; start = 1'b0;
        stop = 1'b0; auto_reload = 1'b0;

        // Reset, then idle.
        cycle(); cycle();
        check_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cycle();
        check_all("idle", 8'd0, 1'b0, 1'b0, 1'b0);

        // Load 4, start, count 4,3,2,1,0.
        load = 1'b1; load_val = 8'd4;
        cycle();
        load = 1'b0;
        check_all("load4", 8'd4, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check_all("run4", 8'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 3; i >= 1; i--) begin
            cycle();
            check_all($sformatf("run%0d", i), 8'(i), 1'b1, 1'b0, 1'b0);
        end
        cycle();
        check_all("tc0", 8'd0, 1'b0, 1'b1, 1'b1);
        cycle();
        check_all("done_hold", 8'd0, 1'b0, 1'b1, 1'b0);

        // start with q=0: immediate tc, stays DONE, never busy.
        start = 1'b1;
        cycle();
        start = 1'b0;
        check_all("start_zero", 8'd0, 1'b0, 1'b1, 1'b1);
        cycle();
        check_all("start_zero_after", 8'd0, 1'b0, 1'b1, 1'b0);

        // Auto-reload period 3, then stop at q=2.
        load = 1'b1; load_val = 8'd3; auto_reload = 1'b1;
        cycle();
        load = 1'b0;
        check_all("auto_load", 8'd3, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check_all("auto_s", 8'd3, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < 2; p++) begin
            cycle(); check_all("auto_2", 8'd2, 1'b1, 1'b0, 1'b0);
            cycle(); check_all("auto_1", 8'd1, 1'b1, 1'b0, 1'b0);
            cycle(); check_all("auto_rl", 8'd3, 1'b1, 1'b0, 1'b1);
        end
        cycle(); check_all("auto_2b", 8'd2, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check_all("auto_stop", 8'd2, 1'b0, 1'b0, 1'b0);
        auto_reload = 1'b0;

        // Load+start together takes load_val; mid-run load and start are ignored by q.
        load = 1'b1; load_val = 8'h80; start = 1'b1;
        cycle();
        start = 1'b0; load_val = 8'h05;
        check_all("ld_start", 8'h80, 1'b1, 1'b0, 1'b0);
        cycle();
        load = 1'b0; start = 1'b1;
        check_all("mid_load", 8'h7F, 1'b1, 1'b0, 1'b0);
        cycle();
        start = 1'b0;
        check_all("start_busy", 8'h7E, 1'b1, 1'b0, 1'b0);

        // Reset mid-run at q=5.
        for (int i = 0; i < 8'h7E - 5; i++) cycle();
        check_all("pre_rst", 8'd5, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        check_all("mid_rst", 8'd0, 1'b0, 1'b0, 1'b0);

        // Full-range count from 0xFF.
        load = 1'b1; load_val = 8'hFF;
        cycle();
        load = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        check_all("ff_start", 8'hFF, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (busy && n < 300) begin
            n++;
            cycle();
        end
        check("ff_busy_cycles", 32'(n), 32'd255);
        check_all("ff_end", 8'd0, 1'b0, 1'b1, 1'b1);
        cycle();
        check_all("ff_after", 8'd0, 1'b0, 1'b1, 1'b0);

        // stop+load+start in RUN: stop wins, reload_reg still takes the new value.
        load = 1'b1; load_val = 8'd6; start = 1'b1;
        cycle();
        load = 1'b0; start = 1'b0;
        check_all("s6", 8'd6, 1'b1, 1'b0, 1'b0);
        cycle();
        stop = 1'b1; load = 1'b1; load_val = 8'd2; start = 1'b1;
        cycle();
        stop = 1'b0; load = 1'b0; start = 1'b0;
        check_all("stop_wins", 8'd5, 1'b0, 1'b0, 1'b0);
        auto_reload = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        check_all("resume5", 8'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 4; i >= 1; i--) cycle();
        check_all("pre_rl2", 8'd1, 1'b1, 1'b0, 1'b0);
        cycle();
        check_all("rl2", 8'd2, 1'b1, 1'b0, 1'b1);
        stop = 1'b1;
        cycle();
        stop = 1'b0;

        // Auto mode with reload_reg==0 terminates in DONE.
        load = 1'b1; load_val = 8'd3; start = 1'b1;
        cycle();
        start = 1'b0; load_val = 8'd0;
        cycle();
        load = 1'b0;
        check_all("rl0_2", 8'd2, 1'b1, 1'b0, 1'b0);
        cycle();
        cycle();
        check_all("rl0_end", 8'd0, 1'b0, 1'b1, 1'b1);

        // reload_reg==1: tc every cycle.
        load = 1'b1; load_val = 8'd1; start = 1'b1;
        cycle();
        load = 1'b0; start = 1'b0;
        check_all("rl1_s", 8'd1, 1'b1, 1'b0, 1'b0);
        cycle(); check_all("rl1_a", 8'd1, 1'b1, 1'b0, 1'b1);
        cycle(); check_all("rl1_b", 8'd1, 1'b1, 1'b0, 1'b1);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check_all("rl1_stop", 8'd1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
